// File: rtl/uart_rx_ctrl_if.sv
// Receive-FIFO read port between the UART receive controller and its consumer.
// The master side presents the head entry; the slave side accepts it with rd_ready.
interface uart_rx_ctrl_if #(
   parameter int DATA_LENGTH = 8
);
   logic                   rd_valid;
   logic                   rd_ready;
   logic [DATA_LENGTH-1:0] rd_data;
   logic                   rd_par_err;
   logic                   rd_stp_err;

   modport master (
      output rd_valid,
      output rd_data,
      output rd_par_err,
      output rd_stp_err,
      input  rd_ready
   );

   modport slave (
      input  rd_valid,
      input  rd_data,
      input  rd_par_err,
      input  rd_stp_err,
      output rd_ready
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: shadowed runtime configuration applied between frames,
// frame activity tracking with timeout, and a small receive FIFO with error flags.
module uart_rx_ctrl #(
   parameter int DATA_LENGTH = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int DROP_ERR    = 0
) (
   input  logic                   CLK_CTRL,
   input  logic                   RST_CTRL,
   input  logic                   RX_IN,
   input  logic                   cfg_wr,
   input  logic [5:0]             cfg_prescale,
   input  logic                   cfg_par_en,
   input  logic                   cfg_par_typ,
   input  logic                   cfg_rx_en,
   input  logic [DATA_LENGTH-1:0] rx_data,
   input  logic                   rx_data_valid,
   input  logic                   rx_par_err,
   input  logic                   rx_stp_err,
   output logic                   rx_in_gated,
   output logic [5:0]             prescale_out,
   output logic                   par_en_out,
   output logic                   par_typ_out,
   output logic                   busy,
   output logic                   cfg_pending,
   output logic                   cfg_err,
   output logic                   timeout,
   output logic                   overflow,
   input  logic                   ovf_clr,
   uart_rx_ctrl_if.master         rd
);

   localparam int ADDR_W  = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = DATA_LENGTH + 2;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [9:0]  tmo_cnt_q, tmo_cnt_d;
   logic        tmo_set;
   logic [9:0]  tmo_inc;
   logic [9:0]  tmo_limit;
   logic        rx_prev_q;
   logic        start;
   logic        frame_evt;

   logic [5:0]  prescale_q, prescale_shd_q;
   logic        par_en_q, par_en_shd_q;
   logic        par_typ_q, par_typ_shd_q;
   logic        rx_en_q, rx_en_shd_q;
   logic        pending_q;
   logic        cfg_err_q;
   logic        timeout_q;
   logic        overflow_q;
   logic        cfg_ok;
   logic        apply;

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W:0]    wr_ptr_q, rd_ptr_q;
   logic               fifo_empty, fifo_full;
   logic               push_req, push, pop, drop;
   logic [ENTRY_W-1:0] head;

   assign cfg_ok    = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
   assign frame_evt = rx_data_valid | rx_par_err | rx_stp_err;
   assign start     = (state_q == IDLE) & rx_en_q & rx_prev_q & ~RX_IN;
   assign apply     = (state_q == IDLE) & pending_q & ~start;
   assign tmo_inc   = tmo_cnt_q + 10'd1;
   assign tmo_limit = {4'd0, prescale_q} * (10'd11 + {9'd0, par_en_q});

   always_ff @(posedge CLK_CTRL) begin
      if (!RST_CTRL) begin
         state_q   <= IDLE;
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
         rx_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= tmo_set;
         rx_prev_q <= RX_IN;
      end
   end

   // A frame event always wins over a timeout landing in the same cycle.
   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = tmo_cnt_q;
      tmo_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = BUSY;
               tmo_cnt_d = '0;
            end
         end
         BUSY: begin
            if (frame_evt) begin
               state_d = IDLE;
            end else if (tmo_inc == tmo_limit) begin
               state_d = IDLE;
               tmo_set = 1'b1;
            end else begin
               tmo_cnt_d = tmo_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A legal write arriving on the apply cycle keeps the new shadow pending.
   always_ff @(posedge CLK_CTRL) begin
      if (!RST_CTRL) begin
         prescale_q     <= 6'd8;
         par_en_q       <= 1'b0;
         par_typ_q      <= 1'b0;
         rx_en_q        <= 1'b0;
         prescale_shd_q <= 6'd8;
         par_en_shd_q   <= 1'b0;
         par_typ_shd_q  <= 1'b0;
         rx_en_shd_q    <= 1'b0;
         pending_q      <= 1'b0;
         cfg_err_q      <= 1'b0;
      end else begin
         cfg_err_q <= cfg_wr & ~cfg_ok;
         if (apply) begin
            prescale_q <= prescale_shd_q;
            par_en_q   <= par_en_shd_q;
            par_typ_q  <= par_typ_shd_q;
            rx_en_q    <= rx_en_shd_q;
         end
         if (cfg_wr && cfg_ok) begin
            prescale_shd_q <= cfg_prescale;
            par_en_shd_q   <= cfg_par_en;
            par_typ_shd_q  <= cfg_par_typ;
            rx_en_shd_q    <= cfg_rx_en;
            pending_q      <= 1'b1;
         end else if (apply) begin
            pending_q <= 1'b0;
         end
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign push_req   = frame_evt & ~((DROP_ERR != 0) & (rx_par_err | rx_stp_err));
   assign pop        = ~fifo_empty & rd.rd_ready;
   assign push       = push_req & (~fifo_full | pop);
   assign drop       = push_req & fifo_full & ~pop;

   always_ff @(posedge CLK_CTRL) begin
      if (!RST_CTRL) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (drop)         overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge CLK_CTRL) begin
      if (RST_CTRL && push) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= {rx_par_err, rx_stp_err, rx_data};
      end
   end

   assign head          = mem[rd_ptr_q[ADDR_W-1:0]];
   assign rd.rd_valid   = ~fifo_empty;
   assign rd.rd_data    = fifo_empty ? '0   : head[DATA_LENGTH-1:0];
   assign rd.rd_stp_err = fifo_empty ? 1'b0 : head[DATA_LENGTH];
   assign rd.rd_par_err = fifo_empty ? 1'b0 : head[DATA_LENGTH+1];

   assign rx_in_gated  = rx_en_q ? RX_IN : 1'b1;
   assign prescale_out = prescale_q;
   assign par_en_out   = par_en_q;
   assign par_typ_out  = par_typ_q;
   assign busy         = (state_q == BUSY);
   assign cfg_pending  = pending_q;
   assign cfg_err      = cfg_err_q;
   assign timeout      = timeout_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a config-write vector table plus hand sequences for
// busy-time config, timeout, FIFO overflow, error dropping and mid-frame reset.
module tb_uart_rx_ctrl;

   localparam int DL = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          rx_in;
   logic          cfg_wr;
   logic [5:0]    cfg_prescale;
   logic          cfg_par_en, cfg_par_typ, cfg_rx_en;
   logic [DL-1:0] rx_data;
   logic          rx_data_valid, rx_par_err, rx_stp_err;
   logic          ovf_clr;

   logic          rx_in_gated, par_en_out, par_typ_out, busy, cfg_pending, cfg_err, timeout, overflow;
   logic [5:0]    prescale_out;
   logic          d_rx_in_gated, d_par_en_out, d_par_typ_out, d_busy, d_cfg_pending, d_cfg_err, d_timeout, d_overflow;
   logic [5:0]    d_prescale_out;

   uart_rx_ctrl_if #(.DATA_LENGTH(DL)) rd0 ();
   uart_rx_ctrl_if #(.DATA_LENGTH(DL)) rd1 ();

   uart_rx_ctrl #(.DATA_LENGTH(DL), .FIFO_DEPTH(4), .DROP_ERR(0)) dut (
      .CLK_CTRL(clk), .RST_CTRL(rst_n), .RX_IN(rx_in),
      .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
      .cfg_par_typ(cfg_par_typ), .cfg_rx_en(cfg_rx_en),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
      .rx_in_gated(rx_in_gated), .prescale_out(prescale_out), .par_en_out(par_en_out),
      .par_typ_out(par_typ_out), .busy(busy), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
      .timeout(timeout), .overflow(overflow), .ovf_clr(ovf_clr), .rd(rd0.master)
   );

   uart_rx_ctrl #(.DATA_LENGTH(DL), .FIFO_DEPTH(4), .DROP_ERR(1)) dut_drop (
      .CLK_CTRL(clk), .RST_CTRL(rst_n), .RX_IN(rx_in),
      .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
      .cfg_par_typ(cfg_par_typ), .cfg_rx_en(cfg_rx_en),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
      .rx_in_gated(d_rx_in_gated), .prescale_out(d_prescale_out), .par_en_out(d_par_en_out),
      .par_typ_out(d_par_typ_out), .busy(d_busy), .cfg_pending(d_cfg_pending), .cfg_err(d_cfg_err),
      .timeout(d_timeout), .overflow(d_overflow), .ovf_clr(ovf_clr), .rd(rd1.master)
   );

   typedef struct {
      logic [5:0] ps;
      logic       pe;
      logic       pt;
      logic       en;
      logic       exp_err;
      logic [5:0] exp_ps;
      logic       exp_pe;
      logic       exp_pt;
   } cfg_vec_t;

   cfg_vec_t vecs [6];
   int errors = 0;
   int checks = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [5:0] ps, input logic pe, input logic pt, input logic en);
      cfg_prescale = ps;
      cfg_par_en   = pe;
      cfg_par_typ  = pt;
      cfg_rx_en    = en;
      cfg_wr       = 1'b1;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic frame(input logic [DL-1:0] d, input logic v, input logic pe, input logic se);
      rx_data       = d;
      rx_data_valid = v;
      rx_par_err    = pe;
      rx_stp_err    = se;
      tick();
      rx_data_valid = 1'b0;
      rx_par_err    = 1'b0;
      rx_stp_err    = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_prescale"}, 32'(prescale_out), 32'd8);
      check_output({tag, "_par_en"}, 32'(par_en_out), 32'd0);
      check_output({tag, "_par_typ"}, 32'(par_typ_out), 32'd0);
      check_output({tag, "_gated"}, 32'(rx_in_gated), 32'd1);
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
      check_output({tag, "_pending"}, 32'(cfg_pending), 32'd0);
      check_output({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
      check_output({tag, "_timeout"}, 32'(timeout), 32'd0);
      check_output({tag, "_overflow"}, 32'(overflow), 32'd0);
      check_output({tag, "_rd_valid"}, 32'(rd0.rd_valid), 32'd0);
      check_output({tag, "_rd_data"}, 32'(rd0.rd_data), 32'd0);
      check_output({tag, "_rd_flags"}, {30'd0, rd0.rd_par_err, rd0.rd_stp_err}, 32'd0);
   endtask

   task automatic drain_check(input string tag, input logic [DL-1:0] exp_d);
      check_output({tag, "_valid"}, 32'(rd0.rd_valid), 32'd1);
      check_output({tag, "_data"}, 32'(rd0.rd_data), 32'(exp_d));
      rd0.rd_ready = 1'b1;
      rd1.rd_ready = 1'b1;
      tick();
      rd0.rd_ready = 1'b0;
      rd1.rd_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int     n;
      logic   done;
      logic [DL-1:0] exp_q [4];

      vecs[0] = '{6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1};
      vecs[1] = '{6'd20, 1'b0, 1'b0, 1'b0, 1'b1, 6'd16, 1'b1, 1'b1};
      vecs[2] = '{6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 6'd16, 1'b1, 1'b1};
      vecs[3] = '{6'd32, 1'b0, 1'b1, 1'b1, 1'b0, 6'd32, 1'b0, 1'b1};
      vecs[4] = '{6'd8,  1'b1, 1'b0, 1'b1, 1'b0, 6'd8,  1'b1, 1'b0};
      vecs[5] = '{6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1};

      rst_n = 1'b0; rx_in = 1'b0; cfg_wr = 1'b0; cfg_prescale = '0;
      cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_rx_en = 1'b0;
      rx_data = '0; rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
      ovf_clr = 1'b0; rd0.rd_ready = 1'b0; rd1.rd_ready = 1'b0;
      tick();
      tick();
      check_reset_state("reset");
      rst_n = 1'b1;
      tick();
      check_output("disabled_gated", 32'(rx_in_gated), 32'd1);
      check_output("disabled_no_start", 32'(busy), 32'd0);
      rx_in = 1'b1;
      tick();

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].ps, vecs[i].pe, vecs[i].pt, vecs[i].en);
         check_output($sformatf("vec%0d_cfg_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
         check_output($sformatf("vec%0d_pending", i), 32'(cfg_pending), 32'(!vecs[i].exp_err));
         tick();
         check_output($sformatf("vec%0d_prescale", i), 32'(prescale_out), 32'(vecs[i].exp_ps));
         check_output($sformatf("vec%0d_par_en", i), 32'(par_en_out), 32'(vecs[i].exp_pe));
         check_output($sformatf("vec%0d_par_typ", i), 32'(par_typ_out), 32'(vecs[i].exp_pt));
         check_output($sformatf("vec%0d_applied", i), 32'(cfg_pending), 32'd0);
         check_output($sformatf("vec%0d_err_clear", i), 32'(cfg_err), 32'd0);
      end

      // Config written mid-frame must wait for the frame to end.
      rx_in = 1'b0;
      tick();
      check_output("start_busy", 32'(busy), 32'd1);
      rx_in = 1'b1;
      apply_stimulus(6'd32, 1'b1, 1'b1, 1'b1);
      check_output("busy_pending", 32'(cfg_pending), 32'd1);
      tick(); tick(); tick();
      check_output("busy_hold_prescale", 32'(prescale_out), 32'd16);
      frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check_output("frame_end_idle", 32'(busy), 32'd0);
      check_output("frame_end_hold", 32'(prescale_out), 32'd16);
      check_output("a5_valid", 32'(rd0.rd_valid), 32'd1);
      check_output("a5_data", 32'(rd0.rd_data), 32'hA5);
      check_output("a5_flags", {30'd0, rd0.rd_par_err, rd0.rd_stp_err}, 32'd0);
      tick();
      check_output("post_frame_prescale", 32'(prescale_out), 32'd32);
      check_output("post_frame_pending", 32'(cfg_pending), 32'd0);
      rd0.rd_ready = 1'b1; rd1.rd_ready = 1'b1;
      tick();
      rd0.rd_ready = 1'b0; rd1.rd_ready = 1'b0;
      check_output("a5_popped", 32'(rd0.rd_valid), 32'd0);

      // Timeout after prescale*(11+par_en) = 88 busy cycles.
      apply_stimulus(6'd8, 1'b0, 1'b0, 1'b1);
      tick();
      check_output("tmo_cfg_prescale", 32'(prescale_out), 32'd8);
      rx_in = 1'b0;
      tick();
      rx_in = 1'b1;
      n = busy ? 1 : 0;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         tick();
         if (busy) n++;
         else done = 1'b1;
      end
      check_output("tmo_reached", 32'(done), 32'd1);
      check_output("tmo_busy_cycles", 32'(n), 32'd88);
      check_output("tmo_pulse", 32'(timeout), 32'd1);
      check_output("tmo_idle", 32'(busy), 32'd0);
      tick();
      check_output("tmo_pulse_end", 32'(timeout), 32'd0);

      // Five pushes into a 4-deep FIFO.
      for (int k = 0; k < 5; k++) frame(8'h10 + 8'(k), 1'b1, 1'b0, 1'b0);
      check_output("ovf_set", 32'(overflow), 32'd1);
      check_output("ovf_head", 32'(rd0.rd_data), 32'h10);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_output("ovf_cleared", 32'(overflow), 32'd0);
      rd0.rd_ready = 1'b1; rd1.rd_ready = 1'b1;
      frame(8'h20, 1'b1, 1'b0, 1'b0);
      rd0.rd_ready = 1'b0; rd1.rd_ready = 1'b0;
      check_output("full_push_pop_no_ovf", 32'(overflow), 32'd0);
      exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h20;
      for (int k = 0; k < 4; k++) drain_check($sformatf("order%0d", k), exp_q[k]);
      check_output("drained", 32'(rd0.rd_valid), 32'd0);

      // Drop coinciding with ovf_clr: set wins.
      for (int k = 0; k < 4; k++) frame(8'h30 + 8'(k), 1'b1, 1'b0, 1'b0);
      ovf_clr = 1'b1;
      frame(8'h34, 1'b1, 1'b0, 1'b0);
      ovf_clr = 1'b0;
      check_output("ovf_set_wins", 32'(overflow), 32'd1);
      for (int k = 0; k < 4; k++) drain_check($sformatf("refill%0d", k), 8'h30 + 8'(k));

      // Error frames: kept with flags, or dropped when DROP_ERR=1.
      frame(8'h3C, 1'b0, 1'b0, 1'b1);
      check_output("stp_valid", 32'(rd0.rd_valid), 32'd1);
      check_output("stp_data", 32'(rd0.rd_data), 32'h3C);
      check_output("stp_flag", 32'(rd0.rd_stp_err), 32'd1);
      check_output("stp_par_flag", 32'(rd0.rd_par_err), 32'd0);
      check_output("drop_stp", 32'(rd1.rd_valid), 32'd0);
      frame(8'h77, 1'b0, 1'b1, 1'b0);
      check_output("drop_par", 32'(rd1.rd_valid), 32'd0);
      frame(8'h5A, 1'b1, 1'b0, 1'b0);
      check_output("drop_good_valid", 32'(rd1.rd_valid), 32'd1);
      check_output("drop_good_data", 32'(rd1.rd_data), 32'h5A);
      check_output("keep_head", 32'(rd0.rd_data), 32'h3C);

      // Reset mid-frame with a config pending.
      rx_in = 1'b0;
      tick();
      check_output("rst_pre_busy", 32'(busy), 32'd1);
      apply_stimulus(6'd16, 1'b1, 1'b1, 1'b1);
      check_output("rst_pre_pending", 32'(cfg_pending), 32'd1);
      rst_n = 1'b0;
      tick();
      check_reset_state("midrst");
      rst_n = 1'b1;
      rx_in = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sits beside the UART receiver top level. It owns the receiver's runtime configuration: prescale, parity enable, parity type and line enable. A configuration write is held in shadow registers and applied only between frames. The block also tracks frame activity, buffers received bytes and error flags in a small FIFO with a valid/ready read port, and flags overflow, timeout and illegal configuration.

Parameters:
DATA_LENGTH, 8, width of received data word
FIFO_DEPTH, 4, receive FIFO entries; power of 2, minimum 2
DROP_ERR, 0, 1 = frames with parity or stop error are not pushed; 0 = pushed with flags

Ports:
CLK_CTRL  in  1  receiver clock, same clock as the receiver datapath
RST_CTRL  in  1  reset is synchronous and active-low
RX_IN  in  1  raw serial line
cfg_wr  in  1  one-cycle configuration write strobe
cfg_prescale  in  6  requested prescale
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type
cfg_rx_en  in  1  requested line enable
rx_data  in  DATA_LENGTH  parallel data from receiver
rx_data_valid  in  1  receiver frame-OK pulse
rx_par_err  in  1  receiver parity-error pulse
rx_stp_err  in  1  receiver stop-error pulse
rx_in_gated  out  1  serial line to receiver; forced to 1 while disabled
prescale_out  out  6  active prescale to receiver
par_en_out  out  1  active parity enable
par_typ_out  out  1  active parity type
busy  out  1  frame in progress
cfg_pending  out  1  shadow configuration not yet applied
cfg_err  out  1  one-cycle pulse: illegal prescale rejected
timeout  out  1  one-cycle pulse: frame abandoned
overflow  out  1  sticky; FIFO-full drop occurred
ovf_clr  in  1  clears overflow
rd_valid  out  1  FIFO not empty
rd_ready  in  1  consumer accepts head entry
rd_data  out  DATA_LENGTH  head entry data
rd_par_err  out  1  head entry parity flag
rd_stp_err  out  1  head entry stop flag

Behaviour:
- Reset when RST_CTRL=0 at a clock edge. Reset values:
  - prescale_out=8, par_en_out=0, par_typ_out=0, rx_en=0 (so rx_in_gated=1)
  - shadow registers equal the active values; cfg_pending=0
  - FSM in IDLE; timeout counter 0; FIFO empty; overflow=0
  - all pulse outputs 0; rd_data, rd_par_err and rd_stp_err read 0
- Reset mid-frame or mid-pending abandons everything and gives the same state.
- Config write:
  - cfg_wr with cfg_prescale in {8,16,32}: load shadow, set cfg_pending.
  - Any other prescale: ignore the whole write, pulse cfg_err next cycle, leave existing shadow and pending unchanged.
  - A later cfg_wr overwrites the shadow (last write wins).
- Config apply:
  - Occurs in the cycle after the FSM is in IDLE with cfg_pending=1 and no start detected in that cycle.
  - Copies shadow to active and clears cfg_pending.
  - Never changes active values while busy.
- rx_in_gated = RX_IN when rx_en is active, else 1.
- FSM states IDLE and BUSY:
  - IDLE -> BUSY when rx_en=1 and RX_IN is sampled 1 then 0 on consecutive cycles (falling edge, using a 1-flop history reset to 1). busy=1 in BUSY.
  - BUSY -> IDLE on any frame event (rx_data_valid | rx_par_err | rx_stp_err).
  - BUSY -> IDLE on timeout, with a one-cycle timeout pulse.
- Timeout counter:
  - 10-bit, cleared on IDLE->BUSY, increments each BUSY cycle.
  - Limit = prescale_out*(11+par_en_out); reaching the limit triggers timeout.
  - Arithmetic is unsigned 10-bit; the maximum 32*12=384 cannot wrap.
- Frame event while IDLE is still pushed; FSM stays IDLE.
- FIFO push:
  - A frame event pushes {rx_par_err, rx_stp_err, rx_data} into the FIFO.
  - When DROP_ERR=1 and either error flag is set, nothing is pushed.
- FIFO read: pop when rd_valid & rd_ready. rd_* show the head entry combinationally from registered storage.
- FIFO full, push without pop: entry dropped, overflow set.
- FIFO full, push with pop in the same cycle: both occur, no overflow.
- FIFO empty: push is visible as rd_valid=1 the next cycle; rd_ready is ignored.
- FIFO pointers are ADDR_W+1 bits and wrap modulo 2*FIFO_DEPTH.
- Overflow flag: ovf_clr clears it; if ovf_clr and a drop occur in the same cycle, set wins.

Test Plan:
- Reset, then cfg_wr(prescale=16, par_en=1, par_typ=1, rx_en=1) while idle -> cfg_pending=1 for 1 cycle, then prescale_out=16, par_en_out=1, par_typ_out=1, cfg_pending=0.
- Falling RX_IN with rx_en=1, then cfg_wr(prescale=32) while busy -> prescale_out stays 16 until rx_data_valid with rx_data=0xA5 returns the FSM to IDLE; then prescale_out=32; FIFO head 0xA5, flags 0.
- cfg_wr(prescale=20) -> cfg_err pulse; shadow and active values unchanged.
- Start edge with no frame event, prescale=8, par_en=0 -> timeout pulse after 88 BUSY cycles, busy=0.
- 5 frame events with rd_ready=0, FIFO_DEPTH=4 -> rd_valid=1, 4 entries in order, overflow=1. Then a push with simultaneous pop while full -> no extra overflow, order preserved. Then ovf_clr -> overflow=0.
- DROP_ERR=1, rx_par_err pulse -> FIFO unchanged. DROP_ERR=0, rx_stp_err with 0x3C -> entry 0x3C with rd_stp_err=1. Then assert RST_CTRL=0 mid-frame -> every output returns to its reset value.
